// File: rtl/sequenciador_pc.sv
// sequenciador_pc: multicycle fetch/decode/execute/memory/write-back sequencer
// owning the program counter, memory/register strobes and retired-instruction count.
`default_nettype none

module sequenciador_pc #(
  parameter logic [31:0] PC_INICIAL = 32'd0,
  parameter logic [31:0] PC_MAX     = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        habilita,
  input  logic [31:0] instrucao,
  input  logic        desvio,
  output logic [31:0] pc,
  output logic [3:0]  estado,
  output logic        le_mem,
  output logic        escreve_mem,
  output logic        escreve_reg,
  output logic        parado,
  output logic        erro_pc,
  output logic [31:0] retiradas
);

  typedef enum logic [3:0] {
    BUSCA      = 4'b0000,
    DECODIFICA = 4'b0001,
    EXECUTA    = 4'b0010,
    MEMORIA    = 4'b0011,
    ESCRITA    = 4'b0100,
    PARADO     = 4'b1111
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  estado_t            r_estado;
  estado_t            w_prox;
  logic [31:0]        r_pc;
  logic [31:0]        r_retiradas;
  logic               r_erro_pc;
  logic [6:0]         w_opcode;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_desloc;
  logic [31:0]        w_alvo;
  logic               w_fora;
  logic               w_conclui;

  assign w_opcode = instrucao[6:0];
  assign w_imm_b  = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                     instrucao[30:25], instrucao[11:8], 1'b0};

  // Only a taken branch leaving EXECUTA jumps; every other completion steps by one word.
  assign w_desloc = (r_estado == EXECUTA && w_opcode == OP_BRANCH && desvio)
                    ? (w_imm_b >>> 2) : 32'sd1;
  assign w_alvo   = r_pc + w_desloc;
  assign w_fora   = w_alvo[31] || ($signed(w_alvo) > $signed(PC_MAX));

  always_comb begin
    w_prox    = r_estado;
    w_conclui = 1'b0;
    case (r_estado)
      BUSCA: w_prox = DECODIFICA;
      DECODIFICA: begin
        if (instrucao == 32'd0) begin
          w_prox = PARADO;
        end else begin
          case (w_opcode)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH: w_prox = EXECUTA;
            default:                                  w_conclui = 1'b1;
          endcase
        end
      end
      EXECUTA: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_prox = MEMORIA;
          OP_R, OP_I:        w_prox = ESCRITA;
          default:           w_conclui = 1'b1;
        endcase
      end
      MEMORIA: begin
        if (w_opcode == OP_LOAD) w_prox = ESCRITA;
        else                     w_conclui = 1'b1;
      end
      ESCRITA: w_conclui = 1'b1;
      PARADO:  w_prox = PARADO;
      default: w_prox = PARADO;
    endcase
    if (w_conclui) w_prox = w_fora ? PARADO : BUSCA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado    <= BUSCA;
      r_pc        <= PC_INICIAL;
      r_retiradas <= 32'd0;
      r_erro_pc   <= 1'b0;
    end else if (habilita) begin
      r_estado <= w_prox;
      if (w_conclui) begin
        if (w_fora) begin
          r_erro_pc <= 1'b1;
        end else begin
          r_pc <= w_alvo;
          if (r_retiradas != 32'hFFFF_FFFF) r_retiradas <= r_retiradas + 32'd1;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign estado      = r_estado;
  assign retiradas   = r_retiradas;
  assign erro_pc     = r_erro_pc;
  assign parado      = (r_estado == PARADO);
  assign le_mem      = habilita && (r_estado == MEMORIA) && (w_opcode == OP_LOAD);
  assign escreve_mem = habilita && (r_estado == MEMORIA) && (w_opcode == OP_STORE);
  assign escreve_reg = habilita && (r_estado == ESCRITA);

endmodule

`default_nettype wire

// File: doc/sequenciador_pc.md
# sequenciador_pc

Multicycle control sequencer that sits directly upstream of the instruction-fetch memory. It owns the program counter (a word index into instruction memory) and the 4-bit `estado` bus that paces fetch, decode, execute, memory and write-back. It inspects the fetched `instrucao` to choose each instruction's state path, applies sequential or branch PC updates, and halts on an all-zero instruction or an out-of-range PC.

## Interface
- `PC_INICIAL`, default 0: PC word index loaded at reset.
- `PC_MAX`, default 10: last valid instruction-memory index. Any PC target above it, or negative, is an error.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `habilita` input 1: step enable. 0 freezes all registered state.
- `instrucao` input 32: fetched instruction, registered by the fetch stage on the edge that leaves BUSCA.
- `desvio` input 1: branch-taken flag from the ALU. Sampled only in EXECUTA for branch opcodes.
- `pc` output 32: word index presented to the fetch stage.
- `estado` output 4: current state.
- `le_mem` output 1: data-memory read strobe.
- `escreve_mem` output 1: data-memory write strobe.
- `escreve_reg` output 1: register-file write strobe.
- `parado` output 1: processor halted.
- `erro_pc` output 1: halt was caused by an out-of-range PC.
- `retiradas` output 32: count of completed instructions.

## Operation
- State encodings:
  - BUSCA = 0000 (mandatory, since fetch captures when `estado` == 0000)
  - DECODIFICA = 0001
  - EXECUTA = 0010
  - MEMORIA = 0011
  - ESCRITA = 0100
  - PARADO = 1111
- Transitions:
  - BUSCA → DECODIFICA, always.
  - In DECODIFICA, `instrucao[6:0]` selects the path:
    - load 0000011: EXECUTA → MEMORIA → ESCRITA → BUSCA.
    - store 0100011: EXECUTA → MEMORIA → BUSCA.
    - R 0110011 / I-ALU 0010011: EXECUTA → ESCRITA → BUSCA.
    - branch 1100011: EXECUTA → BUSCA.
    - `instrucao` == 0: → PARADO.
    - any other opcode: treated as no-op, → BUSCA with pc+1.
- PC update:
  - pc changes only on the edge that enters BUSCA. Default target is pc+1.
  - Branch with `desvio`=1: target = pc + (imm_B >>> 2), signed. imm_B = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, sign-extended to 32 bits.
  - If the target is > PC_MAX or negative: go to PARADO instead of BUSCA, pc holds, `erro_pc`=1.
  - A branch target equal to the current pc is legal.
- Strobes (combinational from `estado` and opcode, forced 0 when `habilita`=0):
  - `le_mem`=1 only in MEMORIA for load.
  - `escreve_mem`=1 only in MEMORIA for store.
  - `escreve_reg`=1 only in ESCRITA.
- Counter: `retiradas` increments by 1 on every edge that enters BUSCA from a completed instruction (no-op included). Saturates at 32'hFFFFFFFF.
- PARADO is absorbing until reset. Once there, `parado`=1 and `pc`/`retiradas` are frozen.

## Timing
- Reset value of every output:
  - `pc`=PC_INICIAL
  - `estado`=BUSCA
  - `parado`=0, `erro_pc`=0
  - `retiradas`=0
  - all strobes 0
- Reset takes effect immediately on assertion. Reset mid-instruction abandons the instruction with no count and no PC update.
- Cycles per instruction (BUSCA through last state): load 5, store 4, R/I 4, branch 3, no-op 2. Halt is reached 2 cycles after entering BUSCA.
- `instrucao` is valid from DECODIFICA onward and is stable through the end of the instruction, because fetch only updates in BUSCA.
- `habilita`=0 on an edge: no register changes. The block resumes exactly where it stopped.
- `desvio` is sampled on the edge leaving EXECUTA. Its value in other states is ignored.
- A `habilita` toggle in the same cycle as a halt condition: the halt happens on the first enabled edge.

## Test plan
- Reset, then stream R-type 0x405282B3 with `habilita`=1 → `estado` 0,1,2,4,0; pc 0→1 on cycle 4; `escreve_reg` high exactly one cycle; `retiradas`=1.
- Load 0x0000A003 at pc 0, then store 0x0021A223 → load takes 5 cycles with `le_mem` pulse in MEMORIA; store takes 4 with `escreve_mem` pulse; pc=2, `retiradas`=2.
- Branch 0x00000463 at pc 6: with `desvio`=1 → pc=8 after 3 cycles; with `desvio`=0 → pc=7.
- Branch with imm_B=+16 at pc 9 and PC_MAX=10 → PARADO, `erro_pc`=1, pc stays 9, `retiradas` unchanged.
- `instrucao`=0 at pc 10 → PARADO two cycles after BUSCA, `parado`=1, `erro_pc`=0. Toggling `habilita` changes nothing.
- Deassert `habilita` in MEMORIA of a load for 3 cycles, then assert `rst`=0 mid-ESCRITA → freeze honoured with strobes 0; reset immediately gives pc=0, `estado`=0, `retiradas`=0.
